// File: rtl/spram_sequencer.sv
// Fill/verify engine for one spram instance: writes a constant pattern over
// an inclusive, wrapping address range or reads it back and checks it.
module spram_sequencer #(
    parameter int address_width = 8,
    parameter int data_width    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     op,
    input  logic [address_width-1:0] first_addr,
    input  logic [address_width-1:0] last_addr,
    input  logic [data_width-1:0]    pattern,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [address_width-1:0] error_address,
    output logic                     mem_enable,
    output logic [address_width-1:0] mem_address,
    output logic [data_width-1:0]    mem_data,
    output logic                     mem_wren,
    input  logic [data_width-1:0]    mem_q
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_VERIFY = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [address_width-1:0] ADDR_ONE =
        {{(address_width-1){1'b0}}, 1'b1};

    logic [2:0]               r_state;
    logic [address_width-1:0] r_last;
    logic [data_width-1:0]    r_pattern;
    logic                     r_rd_valid;
    logic [address_width-1:0] r_rd_addr;

    logic                     w_at_last;
    logic                     w_miss;

    assign w_at_last = (mem_address == r_last);
    // mem_q carries the word addressed one cycle earlier (tagged by r_rd_addr)
    assign w_miss    = r_rd_valid && (mem_q != r_pattern);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_last        <= '0;
            r_pattern     <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_addr     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            error_address <= '0;
            mem_enable    <= 1'b0;
            mem_address   <= '0;
            mem_data      <= '0;
            mem_wren      <= 1'b0;
        end else begin
            done       <= 1'b0;
            r_rd_valid <= 1'b0;

            if (w_miss && !error) begin
                error         <= 1'b1;
                error_address <= r_rd_addr;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_last        <= last_addr;
                        r_pattern     <= pattern;
                        error         <= 1'b0;
                        error_address <= '0;
                        mem_address   <= first_addr;
                        mem_data      <= pattern;
                        mem_enable    <= 1'b1;
                        mem_wren      <= ~op;
                        busy          <= 1'b1;
                        r_state       <= op ? S_VERIFY : S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_at_last) begin
                        mem_enable <= 1'b0;
                        mem_wren   <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        mem_address <= mem_address + ADDR_ONE;
                    end
                end
                S_VERIFY: begin
                    r_rd_valid <= 1'b1;
                    r_rd_addr  <= mem_address;
                    if (w_at_last) begin
                        mem_enable <= 1'b0;
                        r_state    <= S_DRAIN;
                    end else begin
                        mem_address <= mem_address + ADDR_ONE;
                    end
                end
                S_DRAIN: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spram_sequencer.sv
// Randomized bench for spram_sequencer against an array-based RAM model and a
// range-level reference of what each command should do.
module tb_spram_sequencer;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] pattern = '0;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] error_address;
    logic          mem_enable;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    spram_sequencer #(.address_width(AW), .data_width(DW)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .op            (op),
        .first_addr    (first_addr),
        .last_addr     (last_addr),
        .pattern       (pattern),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .error_address (error_address),
        .mem_enable    (mem_enable),
        .mem_address   (mem_address),
        .mem_data      (mem_data),
        .mem_wren      (mem_wren),
        .mem_q         (mem_q)
    );

    always #5 clock = ~clock;

    // spram: registered q, one cycle of read latency
    always @(posedge clock) begin
        if (mem_enable) begin
            if (mem_wren) ram[mem_address] <= mem_data;
            else mem_q <= ram[mem_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_ram(input string tag);
        int diffs = 0;
        for (int a = 0; a < DEPTH; a++)
            if (ram[a] !== ref_mem[a]) diffs++;
        check(tag, diffs, 0);
    endtask

    // poke: fire foreign starts while busy and in the DONE cycle
    // rst_at: assert reset during that cycle of the op (0 = never)
    task automatic run(input bit o, input int f, input int l, input int p,
                       input bit poke, input int rst_at);
        int n;
        int first_err;
        int dc;
        int busy_cyc;
        int bad;
        int wq[$];
        int rq[$];
        n         = ((l - f) & (DEPTH - 1)) + 1;
        first_err = -1;
        dc        = 0;
        busy_cyc  = 0;
        if (o) begin
            for (int i = 0; i < n; i++) begin
                int a = (f + i) % DEPTH;
                if (first_err < 0 && ref_mem[a] != p[DW-1:0]) first_err = a;
            end
        end

        @(negedge clock);
        start      = 1'b1;
        op         = o;
        first_addr = f[AW-1:0];
        last_addr  = l[AW-1:0];
        pattern    = p[DW-1:0];

        for (int c = 1; c <= 2 * DEPTH + 8; c++) begin
            @(negedge clock);
            if (mem_enable && mem_wren) wq.push_back(int'(mem_address));
            if (mem_enable && !mem_wren) rq.push_back(int'(mem_address));
            if (busy) busy_cyc++;
            start      = 1'b0;
            op         = 1'($urandom);
            first_addr = AW'($urandom);
            last_addr  = AW'($urandom);
            pattern    = DW'($urandom);
            if (poke && c == 2) start = 1'b1;
            if (c == rst_at) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                check("rst_wren", mem_wren, 0);
                check("rst_en", mem_enable, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_addr", mem_address, 0);
                check("rst_nwr", wq.size(), rst_at);
                for (int i = 0; i < rst_at; i++)
                    ref_mem[(f + i) % DEPTH] = p[DW-1:0];
                check_ram("rst_ram");
                return;
            end
            if (done) begin
                dc = c;
                if (poke) start = 1'b1;
                break;
            end
        end
        if (poke) begin
            @(negedge clock);
            start = 1'b0;
            check("poke_idle", {busy, mem_enable}, 0);
        end

        check("done_cyc", dc, o ? n + 2 : n + 1);
        check("busy_cyc", busy_cyc, o ? n + 1 : n);
        check("n_wr", wq.size(), o ? 0 : n);
        check("n_rd", rq.size(), o ? n : 0);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i] != (f + i) % DEPTH) bad++;
        for (int i = 0; i < rq.size(); i++)
            if (rq[i] != (f + i) % DEPTH) bad++;
        check("addr_seq", bad, 0);
        check("error", error, (o && first_err >= 0) ? 1 : 0);
        check("err_addr", error_address, first_err >= 0 ? first_err : 0);

        if (!o)
            for (int i = 0; i < n; i++) ref_mem[(f + i) % DEPTH] = p[DW-1:0];
        check_ram("ram");
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            ram[a]     = DW'($urandom);
            ref_mem[a] = ram[a];
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rv_busy", busy, 0);
        check("rv_done", done, 0);
        check("rv_error", error, 0);
        check("rv_eaddr", error_address, 0);
        check("rv_bus", {mem_enable, mem_wren, mem_address, mem_data}, 0);

        run(0, 'h10, 'h13, 'hA5, 0, 0);
        run(1, 'h10, 'h13, 'hA5, 0, 0);
        run(0, 'h12, 'h12, 'h00, 0, 0);
        run(1, 'h10, 'h13, 'hA5, 0, 0);
        run(0, 'hFE, 'h01, 'h3C, 0, 0);
        run(0, 'h40, 'h40, 'h77, 0, 0);
        run(0, 'h20, 'h27, 'h11, 1, 0);
        run(1, 'h20, 'h27, 'h12, 1, 0);
        run(0, 'h00, 'h0F, 'h6B, 0, 3);
        run(0, 'h80, 'h7F, 'h5A, 0, 0);
        run(1, 'h81, 'h80, 'h5A, 0, 0);

        for (int k = 0; k < 24; k++) begin
            int f   = int'($urandom_range(0, DEPTH - 1));
            int len = int'($urandom_range(1, 24));
            int p   = ($urandom_range(0, 1) != 0) ? 'h5A : 'hC3;
            run(1'($urandom), f, (f + len - 1) % DEPTH, p, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spram_sequencer.md
# spram_sequencer

Bus-master engine for one `spram` instance: on command it fills an inclusive address range with a constant pattern, or reads the range back and checks every word against that pattern. It sits between core control logic (reset-time RAM clear, self-test) and the RAM's port. It drives the RAM's enable, address, data and write-enable pins, and consumes its registered `q` output, which has one cycle of read latency.

## Interface
Parameters:
- `address_width`, 8, RAM address width; must match the attached `spram`.
- `data_width`, 8, RAM word width; must match the attached `spram`.

Ports:
- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `op`  in  1  0 = FILL, 1 = VERIFY; sampled with `start`.
- `first_addr`  in  address_width  first address of the range; sampled with `start`.
- `last_addr`  in  address_width  last address of the range, inclusive; sampled with `start`.
- `pattern`  in  data_width  word to write or compare; sampled with `start`.
- `busy`  out  1  high while a command is executing.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  VERIFY mismatch seen; sticky until the next accepted command.
- `error_address`  out  address_width  address of the first mismatch.
- `mem_enable`  out  1  to `spram` `enable`.
- `mem_address`  out  address_width  to `spram` `address`.
- `mem_data`  out  data_width  to `spram` `data`.
- `mem_wren`  out  1  to `spram` `wren`.
- `mem_q`  in  data_width  from `spram` `q`.

## Operation
- States: IDLE, FILL, VERIFY, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `op`, range and `pattern`.
  - Clears `error` and `error_address` to 0.
  - Loads `mem_address`=`first_addr`.
  - Next state is FILL or VERIFY, per `op`.
- Range length N = ((`last_addr` − `first_addr`) mod 2^address_width) + 1.
  - The address counter increments modulo 2^address_width.
  - `last_addr` < `first_addr` wraps through the top of memory to 0.
  - `first_addr` = `last_addr` gives N = 1.
  - `first_addr` = `last_addr` + 1 (mod) gives N = 2^address_width, the whole RAM.
- FILL: `mem_enable`=1, `mem_wren`=1, `mem_data`=`pattern` for each of N consecutive cycles, address stepping by one each cycle. After the cycle with `mem_address`=`last_addr`, go to DONE.
- VERIFY: `mem_enable`=1, `mem_wren`=0 for N consecutive issue cycles, address stepping by one each cycle. After the last issue, go to DRAIN.
- Compare pipeline:
  - An address issued in cycle k has its data on `mem_q` in cycle k+1.
  - A one-deep valid bit plus an address register tag each issued read.
  - Compare `mem_q` with `pattern` in cycle k+1.
- DRAIN: one cycle with `mem_enable`=0. It compares the final read, then goes to DONE.
- Mismatch handling:
  - The first mismatch sets `error`=1 and captures its address into `error_address`.
  - Later mismatches do not overwrite `error_address`.
  - The operation always runs to completion; there is no early abort.
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then IDLE. `start` is ignored in DONE.
- `start` is ignored while `busy`=1. Command inputs may change freely after acceptance.
- FILL never sets `error`.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `error`=0, `error_address`=0, `mem_enable`=0, `mem_wren`=0, `mem_address`=0, `mem_data`=0. State is IDLE.
- `start` accepted at edge T:
  - `busy`=1 from T+1.
  - First memory access is in cycle T+1.
- FILL, N words:
  - Writes in cycles T+1..T+N.
  - `done` in cycle T+N+1.
- VERIFY, N words:
  - Reads issued in cycles T+1..T+N.
  - DRAIN in cycle T+N+1.
  - `done` in cycle T+N+2.
  - `error` is final when `done` is high.
- Back-to-back commands: the earliest new `start` is accepted at the edge ending the IDLE cycle after DONE.
- `reset` mid-operation:
  - At the next edge, state is IDLE and all outputs take their reset values.
  - `mem_wren`=0 and `mem_enable`=0 in the first cycle after the reset edge.
  - No `done` pulse is produced.
  - The partial fill is left in RAM.
- Throughput: one word per cycle in both ops, with no gaps.

## Test plan
- FILL `first_addr`=0x10, `last_addr`=0x13, `pattern`=0xA5, start at T.
  - Expect `mem_wren`=1 in T+1..T+4 at addresses 0x10..0x13.
  - Expect `done` in T+5.
  - RAM words 0x0F and 0x14 are unchanged.
- VERIFY the same range with 0xA5 → `done` in T+6, `error`=0.
- Overwrite word 0x12 with 0x00, VERIFY 0x10..0x13 with 0xA5 → `error`=1, `error_address`=0x12. All four reads still occur, and `done` is in T+6.
- Wrap case: FILL `first_addr`=0xFE, `last_addr`=0x01, `pattern`=0x3C.
  - Expect writes to 0xFE, 0xFF, 0x00, 0x01 in that order.
  - Then run FILL 0x40..0x40 → exactly one write.
- Pulse `start` with different arguments while `busy`=1 and during the DONE cycle → both are ignored; the original op completes unaltered.
- Assert `reset` in the 3rd write cycle of FILL 0x00..0x0F.
  - Expect `mem_wren`=0, `busy`=0, `done`=0 the next cycle.
  - Words 0x00..0x02 hold `pattern`; 0x03..0x0F are untouched.
